alu_op_sequencer: RTL and testbench

Multi-cycle issuing front end for the 32-bit datapath ALU. It accepts an operation as ALUOp/funct/shamt plus two operands over a valid/ready handshake and decodes it into the ALU's 4-bit control code. It drives the external combinational ALU for one or more cycles, registers the ALU result and Zero flag, and returns them over a second valid/ready handshake. Logical left shifts (`sll`) run on the ALU itself as repeated self-additions, so no separate shifter is needed.

---
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue front end for the 32-bit ALU: decodes ALUOp/funct, drives the
// external ALU (repeated self-adds for sll) and returns the registered result/Zero.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  code_q;
    logic        sll_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        err_q;

    logic        dec_legal;
    logic        dec_sll;
    logic [3:0]  dec_code;
    logic        accept;
    logic        exec_last;

    always_comb begin
        dec_legal = 1'b1;
        dec_sll   = 1'b0;
        dec_code  = 4'd0;
        case (alu_op)
            2'b00: dec_code = 4'd2;
            2'b01: dec_code = 4'd6;
            2'b10: begin
                case (funct)
                    6'b100000: dec_code = 4'd2;
                    6'b100010: dec_code = 4'd6;
                    6'b100100: dec_code = 4'd0;
                    6'b100101: dec_code = 4'd1;
                    6'b100111: dec_code = 4'd12;
                    6'b101010: dec_code = 4'd7;
                    6'b000000: dec_sll  = 1'b1;
                    default:   dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && in_valid;

    // sll with shamt 0 is a single OR-with-zero pass; otherwise stop after the
    // pass that takes the counter from 1 to 0.
    assign exec_last = !sll_q || (cnt_q <= 5'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_ctl   = '0;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = dec_legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (!sll_q) begin
                    alu_ctl = code_q;
                    alu_a   = a_q;
                    alu_b   = b_q;
                end else if (cnt_q == 5'd0) begin
                    alu_ctl = 4'd1;
                    alu_a   = a_q;
                    alu_b   = '0;
                end else begin
                    alu_ctl = 4'd2;
                    alu_a   = a_q;
                    alu_b   = a_q;
                end
                if (exec_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            code_q   <= '0;
            sll_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= op_a;
                b_q    <= op_b;
                code_q <= dec_code;
                sll_q  <= dec_sll;
                cnt_q  <= shamt;
                if (dec_legal) begin
                    err_q <= 1'b0;
                end else begin
                    result_q <= '0;
                    zero_q   <= 1'b0;
                    err_q    <= 1'b1;
                end
            end
            if (state == EXEC) begin
                if (sll_q && (cnt_q != 5'd0)) begin
                    a_q   <= alu_out;
                    cnt_q <= cnt_q - 5'd1;
                end
                if (exec_last) begin
                    result_q <= alu_out;
                    zero_q   <= alu_zero;
                end
            end
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the ALU-side ports.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        err;

    int passed = 0;
    int total  = 0;

    alu_op_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_ctl   (alu_ctl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'hBAD0BAD0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] aop, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [3:0] ctl1, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_err, input int hold);
        int cyc;
        @(negedge clk);
        chk({tag, "/idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "/idle_ctl"}, {28'd0, alu_ctl}, 32'd0);
        alu_op   = aop;
        funct    = fn;
        shamt    = sh;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = 32'hDEADBEEF;
        op_b     = 32'h13579BDF;
        alu_op   = 2'b11;
        funct    = 6'b111111;
        shamt    = 5'd31;
        chk({tag, "/ctl_t1"}, {28'd0, alu_ctl}, {28'd0, ctl1});
        chk({tag, "/busy_ready"}, {31'd0, in_ready}, 32'd0);
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "/latency"}, cyc, lat);
        chk({tag, "/result"}, result, exp_res);
        chk({tag, "/zero"}, {31'd0, zero}, {31'd0, exp_zero});
        chk({tag, "/err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "/done_ctl"}, {28'd0, alu_ctl}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "/hold_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "/hold_result"}, result, exp_res);
            chk({tag, "/hold_err"}, {31'd0, err}, {31'd0, exp_err});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "/drain_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "/drain_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct     = 6'd0;
        shamt     = 5'd0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst/result", result, 32'd0);
        chk("rst/zero", {31'd0, zero}, 32'd0);
        chk("rst/err", {31'd0, err}, 32'd0);
        chk("rst/alu_ctl", {28'd0, alu_ctl}, 32'd0);
        chk("rst/alu_a", alu_a, 32'd0);
        chk("rst/alu_b", alu_b, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add",     2'b10, 6'b100000, 5'd0, 32'd5,          32'd7,          2,  4'd2,  32'd12,         1'b0, 1'b0, 0);
        run_op("beq_sub", 2'b01, 6'b000000, 5'd0, 32'h1234,       32'h1234,       2,  4'd6,  32'd0,          1'b1, 1'b0, 0);
        run_op("nor",     2'b10, 6'b100111, 5'd0, 32'd0,          32'hFFFF0000,   2,  4'd12, 32'h0000FFFF,   1'b0, 1'b0, 0);
        run_op("slt",     2'b10, 6'b101010, 5'd0, 32'd3,          32'd9,          2,  4'd7,  32'd1,          1'b0, 1'b0, 0);
        run_op("sll4",    2'b10, 6'b000000, 5'd4, 32'h80000001,   32'h0,          5,  4'd2,  32'h00000010,   1'b0, 1'b0, 0);
        run_op("sll0",    2'b10, 6'b000000, 5'd0, 32'h80000001,   32'h5555AAAA,   2,  4'd1,  32'h80000001,   1'b0, 1'b0, 0);
        run_op("sll16z",  2'b10, 6'b000000, 5'd16, 32'h00010000,  32'h0,          17, 4'd2,  32'h00000000,   1'b1, 1'b0, 0);
        run_op("sll31",   2'b10, 6'b000000, 5'd31, 32'h00000003,  32'h0,          32, 4'd2,  32'h80000000,   1'b0, 1'b0, 0);
        run_op("ill_op",  2'b11, 6'b100000, 5'd0, 32'd5,          32'd7,          1,  4'd0,  32'd0,          1'b0, 1'b1, 0);
        run_op("lw_add",  2'b00, 6'b111111, 5'd0, 32'd1,          32'd2,          2,  4'd2,  32'd3,          1'b0, 1'b0, 0);
        run_op("ill_fn",  2'b10, 6'b111111, 5'd0, 32'd5,          32'd7,          1,  4'd0,  32'd0,          1'b0, 1'b1, 0);
        run_op("and_hld", 2'b10, 6'b100100, 5'd0, 32'h0000F0F0,   32'h0000FF00,   2,  4'd0,  32'h0000F000,   1'b0, 1'b0, 3);
        run_op("rsub",    2'b10, 6'b100010, 5'd0, 32'd10,         32'd3,          2,  4'd6,  32'd7,          1'b0, 1'b0, 0);
        run_op("or",      2'b10, 6'b100101, 5'd0, 32'h0000000F,   32'h000000F0,   2,  4'd1,  32'h000000FF,   1'b0, 1'b0, 0);

        // reset in the middle of a long shift discards it
        @(negedge clk);
        alu_op   = 2'b10;
        funct    = 6'b000000;
        shamt    = 5'd20;
        op_a     = 32'h00000001;
        op_b     = 32'h0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst/busy_ctl", {28'd0, alu_ctl}, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst/out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst/result", result, 32'd0);
        chk("midrst/in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst/alu_ctl", {28'd0, alu_ctl}, 32'd0);
        chk("midrst/alu_a", alu_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("midrst/no_late_valid", {31'd0, out_valid}, 32'd0);

        run_op("post_rst", 2'b00, 6'b000000, 5'd0, 32'd100, 32'd23, 2, 4'd2, 32'd123, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
